lcd_ctrl: RTL and testbench

- Hardware HD44780-style character-LCD write engine.
- The core's load/store path hands it one command or data byte per request over a valid/ready handshake.
- The block generates the LCD bus timing: RS/DATA setup, EN pulse, hold, then the execution wait.
- Software never bit-bangs EN/RS. It polls busy, or holds req_vld until req_rdy.

---
 rtl/lcd_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_lcd_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: HD44780-style character-LCD write engine.
//
// Accepts one command/data byte per valid/ready handshake and generates the
// LCD bus timing: RS/DATA setup (T_AS), EN pulse (T_PW), hold (T_H), then an
// execution wait (T_EXEC, or T_CLR for clear-display / return-home).
//
// Optional build macro LCD_INIT_EN: after reset, wait T_POWERUP cycles and
// issue the init sequence 0x38, 0x0C, 0x01, 0x06 before accepting requests.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_vld    request valid
//   req_rdy    block ready to accept a request
//   req_rs     0 = command, 1 = data
//   req_data   byte to write
//   busy       transfer in progress (~req_rdy)
//   done       one-cycle pulse when a requested transfer completes
//   init_done  power-on init sequence complete
//   lcd_en     LCD enable strobe
//   lcd_rs     LCD register select
//   lcd_rw     LCD read/write, constant 0
//   lcd_data   LCD data bus
module lcd_ctrl #(
    parameter int T_AS      = 2,
    parameter int T_PW      = 12,
    parameter int T_H       = 2,
    parameter int T_EXEC    = 2000,
    parameter int T_CLR     = 82000,
    parameter int T_POWERUP = 750000,
    parameter int CNT_W     = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_vld,
    output logic       req_rdy,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       busy,
    output logic       done,
    output logic       init_done,
    output logic       lcd_en,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data
);

    if (T_AS < 1 || T_PW < 1 || T_H < 1 || T_EXEC < 1 || T_CLR < 1 || T_POWERUP < 1)
    begin : g_bad_timing
        $error("lcd_ctrl: every T_* parameter must be >= 1");
    end

    // Counter reload values: a phase of T cycles counts T-1 down to 0.
    localparam logic [CNT_W-1:0] L_AS   = CNT_W'(T_AS - 1);
    localparam logic [CNT_W-1:0] L_PW   = CNT_W'(T_PW - 1);
    localparam logic [CNT_W-1:0] L_H    = CNT_W'(T_H - 1);
    localparam logic [CNT_W-1:0] L_EXEC = CNT_W'(T_EXEC - 1);
    localparam logic [CNT_W-1:0] L_CLR  = CNT_W'(T_CLR - 1);

`ifdef LCD_INIT_EN
    localparam logic [CNT_W-1:0] L_PWR  = CNT_W'(T_POWERUP - 1);

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WAIT, PWRUP} state_t;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    logic [1:0] init_idx, init_idx_nxt;
`else
    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WAIT} state_t;
`endif

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             rs_nxt;
    logic [7:0]       data_nxt;
    logic             done_nxt;
    logic             init_done_nxt;
    logic             wait_clr;

    assign lcd_rw = 1'b0;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        rs_nxt        = lcd_rs;
        data_nxt      = lcd_data;
        done_nxt      = 1'b0;
        init_done_nxt = init_done;
`ifdef LCD_INIT_EN
        init_idx_nxt  = init_idx;
`endif
        // Clear display (0x01) and return home (0x02/0x03) need the long wait;
        // decided from the already-latched pins so init commands use it too.
        wait_clr = ~lcd_rs && (lcd_data[7:2] == '0) && (lcd_data[1:0] != '0);

        case (state)
            IDLE: begin
                if (req_vld) begin
                    state_nxt = SETUP;
                    cnt_nxt   = L_AS;
                    rs_nxt    = req_rs;
                    data_nxt  = req_data;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_nxt = PULSE;
                    cnt_nxt   = L_PW;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    state_nxt = HOLD;
                    cnt_nxt   = L_H;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_nxt = WAIT;
                    cnt_nxt   = wait_clr ? L_CLR : L_EXEC;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
`ifdef LCD_INIT_EN
                    if (!init_done) begin
                        // Internal init commands chain straight into the next
                        // SETUP and never raise done.
                        if (init_idx == 2'd3) begin
                            state_nxt     = IDLE;
                            init_done_nxt = 1'b1;
                        end else begin
                            init_idx_nxt = init_idx + 2'd1;
                            state_nxt    = SETUP;
                            cnt_nxt      = L_AS;
                            rs_nxt       = 1'b0;
                            data_nxt     = init_cmd(init_idx + 2'd1);
                        end
                    end else begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
`else
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
`endif
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
`ifdef LCD_INIT_EN
            PWRUP: begin
                if (cnt == '0) begin
                    state_nxt = SETUP;
                    cnt_nxt   = L_AS;
                    rs_nxt    = 1'b0;
                    data_nxt  = init_cmd(2'd0);
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
`ifdef LCD_INIT_EN
            state     <= PWRUP;
            cnt       <= L_PWR;
            init_idx  <= 2'd0;
            req_rdy   <= 1'b0;
            busy      <= 1'b1;
            init_done <= 1'b0;
`else
            state     <= IDLE;
            cnt       <= '0;
            req_rdy   <= 1'b1;
            busy      <= 1'b0;
            init_done <= 1'b1;
`endif
            done      <= 1'b0;
            lcd_en    <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_data  <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
`ifdef LCD_INIT_EN
            init_idx  <= init_idx_nxt;
`endif
            req_rdy   <= (state_nxt == IDLE);
            busy      <= (state_nxt != IDLE);
            init_done <= init_done_nxt;
            done      <= done_nxt;
            lcd_en    <= (state_nxt == PULSE);
            lcd_rs    <= rs_nxt;
            lcd_data  <= data_nxt;
        end
    end

endmodule

// File: tb/tb_lcd_ctrl.sv
`timescale 1ns/1ps
module tb_lcd_ctrl;

    localparam int T_AS      = 2;
    localparam int T_PW      = 3;
    localparam int T_H       = 1;
    localparam int T_EXEC    = 5;
    localparam int T_CLR     = 10;
    localparam int T_POWERUP = 20;

    // Observed word layout: {init_done, req_rdy, busy, done, lcd_en, lcd_rs, lcd_data}
`ifdef LCD_INIT_EN
    localparam logic [13:0] RST_WORD = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
`else
    localparam logic [13:0] RST_WORD = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_vld = 1'b0;
    logic       req_rs = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       req_rdy, busy, done, init_done, lcd_en, lcd_rs, lcd_rw;
    logic [7:0] lcd_data;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    lcd_ctrl #(
        .T_AS(T_AS), .T_PW(T_PW), .T_H(T_H), .T_EXEC(T_EXEC),
        .T_CLR(T_CLR), .T_POWERUP(T_POWERUP), .CNT_W(20)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_rs(req_rs), .req_data(req_data),
        .busy(busy), .done(done), .init_done(init_done),
        .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data)
    );

    // Reference model: execution wait from the HD44780 command classes.
    function automatic int wait_len(input logic rs, input logic [7:0] d);
        if (!rs && d >= 8'd1 && d <= 8'd3) return T_CLR;
        return T_EXEC;
    endfunction

    // Expected pins k cycles after the acceptance edge of an n-cycle transfer.
    function automatic logic [13:0] expect_at(input int k, input int n,
                                              input logic rs, input logic [7:0] d);
        logic rdy, en, dn;
        rdy = (k > n);
        en  = (k > T_AS) && (k <= T_AS + T_PW);
        dn  = (k == n + 1);
        return {1'b1, rdy, ~rdy, dn, en, rs, d};
    endfunction

    function automatic logic [13:0] observed();
        return {init_done, req_rdy, busy, done, lcd_en, lcd_rs, lcd_data};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (observed() !== RST_WORD || lcd_rw !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: got %h rw=%b expected %h rw=0", observed(), lcd_rw, RST_WORD);
        end
        rst_n = 1'b1;
`ifndef LCD_INIT_EN
        @(posedge clk); #1;
        vectors++;
        if (observed() !== RST_WORD) begin
            miscompares++;
            $display("FAIL reset_idle: got %h expected %h", observed(), RST_WORD);
        end
`endif
    endtask

`ifdef LCD_INIT_EN
    task automatic test_init();
        logic [13:0] q[$];
        logic [7:0]  cmds [4];
        int          n;
        cmds[0] = 8'h38; cmds[1] = 8'h0C; cmds[2] = 8'h01; cmds[3] = 8'h06;
        repeat (T_POWERUP) q.push_back(RST_WORD);
        for (int c = 0; c < 4; c++) begin
            n = T_AS + T_PW + T_H + wait_len(1'b0, cmds[c]);
            for (int k = 1; k <= n; k++)
                q.push_back({1'b0, 1'b0, 1'b1, 1'b0,
                             (k > T_AS) && (k <= T_AS + T_PW), 1'b0, cmds[c]});
        end
        q.push_back({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h06});
        for (int p = 0; p < q.size(); p++) begin
            if (p > 0) begin @(posedge clk); #1; end
            vectors++;
            if (observed() !== q[p]) begin
                miscompares++;
                $display("FAIL init cycle %0d: got %h expected %h", p, observed(), q[p]);
            end
        end
    endtask
`endif

    // Single write; entered and left one tick after a clock edge with the DUT idle.
    task automatic test_write(input logic rs, input logic [7:0] d, input string tag);
        int n;
        n = T_AS + T_PW + T_H + wait_len(rs, d);
        req_vld = 1'b1; req_rs = rs; req_data = d;
        @(posedge clk); #1;
        req_vld = 1'b0; req_rs = 1'($urandom); req_data = 8'($urandom);
        for (int k = 1; k <= n + 1; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            vectors++;
            if (observed() !== expect_at(k, n, rs, d)) begin
                miscompares++;
                $display("FAIL %s cycle %0d: got %h expected %h",
                         tag, k, observed(), expect_at(k, n, rs, d));
            end
        end
    endtask

    task automatic test_clear_cmds();
        test_write(1'b0, 8'h01, "clear_01");
        test_write(1'b0, 8'h02, "home_02");
        test_write(1'b0, 8'h03, "home_03");
        test_write(1'b0, 8'h04, "entry_04");
        test_write(1'b0, 8'h00, "cmd_00");
        test_write(1'b1, 8'h01, "data_01");
    endtask

    task automatic test_random_writes();
        logic       rs;
        logic [7:0] d;
        for (int i = 0; i < 24; i++) begin
            rs = 1'($urandom);
            d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            test_write(rs, d, "random");
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        int         n;
        req_vld = 1'b1; req_rs = 1'b1; req_data = 8'h41;
        for (int j = 0; j < 2; j++) begin
            d = (j == 0) ? 8'h41 : 8'h42;
            n = T_AS + T_PW + T_H + wait_len(1'b1, d);
            @(posedge clk); #1;
            if (j == 0) req_data = 8'h42;
            else        req_vld  = 1'b0;
            for (int k = 1; k <= n + 1; k++) begin
                if (k > 1) begin @(posedge clk); #1; end
                vectors++;
                if (observed() !== expect_at(k, n, 1'b1, d)) begin
                    miscompares++;
                    $display("FAIL b2b xfer %0d cycle %0d: got %h expected %h",
                             j, k, observed(), expect_at(k, n, 1'b1, d));
                end
            end
        end
    endtask

    task automatic test_busy_ignore();
        int n;
        n = T_AS + T_PW + T_H + T_EXEC;
        req_vld = 1'b1; req_rs = 1'b1; req_data = 8'h30;
        @(posedge clk); #1;
        for (int k = 1; k <= n + 4; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            vectors++;
            if (observed() !== expect_at(k, n, 1'b1, 8'h30)) begin
                miscompares++;
                $display("FAIL busy_ignore cycle %0d: got %h expected %h",
                         k, observed(), expect_at(k, n, 1'b1, 8'h30));
            end
            req_vld  = (k <= n) ? 1'($urandom) : 1'b0;
            req_rs   = 1'($urandom);
            req_data = 8'($urandom);
        end
        req_vld = 1'b0;
    endtask

    task automatic test_reset_mid();
        req_vld = 1'b1; req_rs = 1'b1; req_data = 8'h55;
        @(posedge clk); #1;
        req_vld = 1'b0;
        repeat (T_AS + 1) @(posedge clk);
        #1;
        vectors++;
        if (lcd_en !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_pulse: lcd_en got %b expected 1", lcd_en);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (observed() !== RST_WORD) begin
            miscompares++;
            $display("FAIL reset_mid_async: got %h expected %h", observed(), RST_WORD);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            vectors++;
            if (observed() !== RST_WORD) begin
                miscompares++;
                $display("FAIL reset_mid_after cycle %0d: got %h expected %h",
                         k, observed(), RST_WORD);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
`ifdef LCD_INIT_EN
        test_init();
`endif
        test_write(1'b1, 8'h41, "data_41");
        test_clear_cmds();
        test_back_to_back();
        test_busy_ignore();
        test_random_writes();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
